// File: rtl/fifo_push_arb.sv
// fifo_push_arb
//    Round-robin arbiter that shares one FIFO push port between R burst
//    requesters. A granted requester owns the port until its last beat is
//    accepted. Backpressure comes only from the FIFO's registered full flag.
//
// Ports
//    clk, rst_n       push-side clock, asynchronous active-low reset
//    req_vld[R]       requester i presents a beat
//    req_data[R*W]    requester i beat at [i*W +: W]
//    req_last[R]      requester i beat is the last of its burst
//    req_rdy[R]       requester i beat accepted this cycle (with req_vld)
//    fifo_full_r      FIFO registered full flag
//    push, push_data  FIFO push strobe and data
//    gnt_r[R]         registered one-hot grant, zero when idle
//    busy_r           high while a burst owns the port
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no owner; pick the first requester at or after ptr_q
// ST_BURST | gnt_q owns the port until its last beat is pushed

module fifo_push_arb #(
   parameter int W = 32,
   parameter int R = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [R-1:0]   req_vld,
   input  logic [R*W-1:0] req_data,
   input  logic [R-1:0]   req_last,
   output logic [R-1:0]   req_rdy,
   input  logic           fifo_full_r,
   output logic           push,
   output logic [W-1:0]   push_data,
   output logic [R-1:0]   gnt_r,
   output logic           busy_r
);

   localparam int PW = (R > 1) ? $clog2(R) : 1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [R-1:0]    gnt_q, gnt_d;
   logic [PW-1:0]   ptr_q, ptr_d;

   logic [R-1:0]    arb_gnt;
   logic [PW-1:0]   gnt_idx;
   logic            accept_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
      end
   end

   // Rotating priority search. Walking from the lowest priority up lets the
   // highest-priority valid requester overwrite any earlier candidate.
   always_comb begin
      int            j;
      logic [PW-1:0] idx;
      arb_gnt = '0;
      j       = 0;
      idx     = '0;
      for (int k = R - 1; k >= 0; k--) begin
         j = int'(ptr_q) + k;
         if (j >= R) j = j - R;
         idx = PW'(j);
         if (req_vld[idx]) begin
            arb_gnt      = '0;
            arb_gnt[idx] = 1'b1;
         end
      end
   end

   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < R; i++) begin
         if (gnt_q[i]) gnt_idx = PW'(i);
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      case (state_q)
         ST_IDLE: begin
            // full does not hold off arbitration; it only blocks pushes
            if (|req_vld) begin
               state_d = ST_BURST;
               gnt_d   = arb_gnt;
            end
         end
         ST_BURST: begin
            if (accept_last) begin
               state_d = ST_IDLE;
               gnt_d   = '0;
               ptr_d   = (gnt_idx == PW'(R - 1)) ? '0 : gnt_idx + PW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   // Everything here is a mux off the one-hot grant, so with gnt_q cleared
   // (idle or in reset) all outputs fall to zero without a clock.
   always_comb begin
      req_rdy     = '0;
      push        = 1'b0;
      push_data   = '0;
      accept_last = 1'b0;
      for (int i = 0; i < R; i++) begin
         if (gnt_q[i]) begin
            req_rdy[i]  = ~fifo_full_r;
            push        = req_vld[i] & ~fifo_full_r;
            push_data   = req_data[i*W +: W];
            accept_last = req_vld[i] & req_last[i] & ~fifo_full_r;
         end
      end
   end

   assign gnt_r  = gnt_q;
   assign busy_r = (state_q == ST_BURST);

endmodule
